// File: rtl/score_ram_responder.sv
// score_ram_responder: leaderboard word store behind the scoring FSM bus.
// Sweeps an init image after reset or clear, then serves one access per cycle.
module score_ram_responder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter logic [15:0] INIT_IDS   = 16'h0000,
  parameter logic [15:0] INIT_SCORE = 16'h0099,
  parameter logic [15:0] INIT_AUX   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scoreRAM_RW,
  input  logic [4:0]  scoreRAM_Addr,
  input  logic [15:0] scoreRAM_Din,
  input  logic        clear_req,
  output logic [15:0] scoreRAM_Dout,
  output logic        ready,
  output logic        oob_err,
  output logic [7:0]  wr_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] DEPTH6 = 6'(DEPTH);
  localparam logic [4:0] LAST = 5'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    SERVE
  } state_t;

  state_t      state;
  logic [4:0]  ptr;
  logic [15:0] mem [DEPTH];
  logic [15:0] pipe [RD_LAT];

  logic          in_range;
  logic [15:0]   rd_word;
  logic [15:0]   cap;
  logic          we;
  logic [AW-1:0] wa;
  logic [15:0]   wd;

  function automatic logic [15:0] init_word(input logic [4:0] a);
    logic [15:0] w;
    unique case (1'b1)
      (a == 5'd0): w = INIT_IDS;
      a[0]:        w = INIT_SCORE;
      default:     w = INIT_AUX;
    endcase
    return w;
  endfunction

  // Out-of-range addresses never alias onto the implemented words.
  assign in_range = {1'b0, scoreRAM_Addr} < DEPTH6;
  assign rd_word  = mem[scoreRAM_Addr[AW-1:0]];

  always_comb begin
    cap = '0;
    if (scoreRAM_RW) begin
      cap = scoreRAM_Din;
    end else if (in_range) begin
      cap = rd_word;
    end
  end

  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    if (!rst && !clear_req) begin
      if (state == CLEAR) begin
        we = 1'b1;
        wa = ptr[AW-1:0];
        wd = init_word(ptr);
      end else if (scoreRAM_RW && in_range) begin
        we = 1'b1;
        wa = scoreRAM_Addr[AW-1:0];
        wd = scoreRAM_Din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      ptr      <= '0;
      oob_err  <= 1'b0;
      wr_count <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      unique case (state)
        CLEAR: begin
          for (int i = 0; i < RD_LAT; i++) begin
            pipe[i] <= '0;
          end
          if (clear_req) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            state <= SERVE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 5'd1;
          end
        end
        SERVE: begin
          if (clear_req) begin
            state   <= CLEAR;
            ptr     <= '0;
            oob_err <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
              pipe[i] <= '0;
            end
          end else begin
            pipe[0] <= cap;
            for (int i = 1; i < RD_LAT; i++) begin
              pipe[i] <= pipe[i-1];
            end
            if (scoreRAM_RW) begin
              if (!in_range) begin
                oob_err <= 1'b1;
              end else if (wr_count != 8'hFF) begin
                wr_count <= wr_count + 8'd1;
              end
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign scoreRAM_Dout = pipe[RD_LAT-1];
  assign ready         = (state == SERVE);

endmodule

// File: tb/tb_score_ram_responder.sv
// tb_score_ram_responder: three latencies side by side against one
// behavioural leaderboard model, directed scenarios then random traffic.
module tb_score_ram_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic        rw;
  logic [4:0]  addr;
  logic [15:0] din;

  logic [15:0] dout1, dout2, dout3;
  logic        ready1, ready2, ready3;
  logic        oob1, oob2, oob3;
  logic [7:0]  wc1, wc2, wc3;

  int n_chk = 0;
  int n_fail = 0;

  int          busy;
  logic [15:0] mmem [DEPTH];
  logic [15:0] hist [3];
  bit          moob;
  int          mwc;

  always #5 clk = ~clk;

  score_ram_responder #(.RD_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .scoreRAM_RW(rw), .scoreRAM_Addr(addr),
    .scoreRAM_Din(din), .clear_req(clear_req), .scoreRAM_Dout(dout1),
    .ready(ready1), .oob_err(oob1), .wr_count(wc1)
  );

  score_ram_responder #(.RD_LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .scoreRAM_RW(rw), .scoreRAM_Addr(addr),
    .scoreRAM_Din(din), .clear_req(clear_req), .scoreRAM_Dout(dout2),
    .ready(ready2), .oob_err(oob2), .wr_count(wc2)
  );

  score_ram_responder #(.RD_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .scoreRAM_RW(rw), .scoreRAM_Addr(addr),
    .scoreRAM_Din(din), .clear_req(clear_req), .scoreRAM_Dout(dout3),
    .ready(ready3), .oob_err(oob3), .wr_count(wc3)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit w,
                       input logic [4:0] a, input logic [15:0] d);
    logic [15:0] cp;
    bit flush;
    @(negedge clk);
    rst = r;
    clear_req = c;
    rw = w;
    addr = a;
    din = d;
    cp = '0;
    flush = 1'b0;
    if (r) begin
      busy = DEPTH;
      moob = 1'b0;
      mwc = 0;
      flush = 1'b1;
    end else if (busy > 0) begin
      busy = c ? DEPTH : busy - 1;
      if (busy == 0) begin
        for (int k = 0; k < DEPTH; k++) begin
          mmem[k] = (k == 0) ? 16'h0000 : ((k % 2) ? 16'h0099 : 16'h0000);
        end
      end
    end else if (c) begin
      busy = DEPTH;
      moob = 1'b0;
      flush = 1'b1;
    end else begin
      if (w) cp = d;
      else if (int'(a) < DEPTH) cp = mmem[a];
      if (w) begin
        if (int'(a) < DEPTH) begin
          mmem[a] = d;
          if (mwc < 255) mwc++;
        end else begin
          moob = 1'b1;
        end
      end
    end
    if (flush) begin
      hist[0] = '0;
      hist[1] = '0;
      hist[2] = '0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = cp;
    end
    @(posedge clk);
    #1;
    check("ready_l2", 32'(ready2), 32'(busy == 0));
    check("ready_l1", 32'(ready1), 32'(busy == 0));
    check("ready_l3", 32'(ready3), 32'(busy == 0));
    check("oob_err", 32'(oob2), 32'(moob));
    check("oob_l13", 32'({oob1, oob3}), 32'({moob, moob}));
    check("wr_count", 32'(wc2), 32'(mwc));
    check("wc_l13", 32'({wc1, wc3}), 32'({mwc[7:0], mwc[7:0]}));
    check("dout_l1", 32'(dout1), 32'(hist[0]));
    check("dout_l2", 32'(dout2), 32'(hist[1]));
    check("dout_l3", 32'(dout3), 32'(hist[2]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 5'd0, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    clear_req = 1'b0;
    rw = 1'b0;
    addr = '0;
    din = '0;
    busy = DEPTH;
    moob = 1'b0;
    mwc = 0;
    for (int k = 0; k < DEPTH; k++) mmem[k] = '0;
    for (int k = 0; k < 3; k++) hist[k] = '0;

    cycle(1, 0, 0, 5'd0, 16'h0);
    cycle(1, 0, 0, 5'd0, 16'h0);
    idle(16);
    cycle(0, 0, 0, 5'd0, 16'h0);
    cycle(0, 0, 0, 5'd1, 16'h0);
    cycle(0, 0, 0, 5'd2, 16'h0);
    idle(3);
    cycle(0, 0, 1, 5'd3, 16'h0042);
    cycle(0, 0, 0, 5'd3, 16'h0);
    idle(3);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 5'd5, 16'h0017);
    cycle(0, 0, 0, 5'd5, 16'h0);
    idle(3);
    cycle(0, 0, 1, 5'd20, 16'h1234);
    cycle(0, 0, 0, 5'd20, 16'h0);
    cycle(0, 0, 0, 5'd4, 16'h0);
    idle(3);
    cycle(0, 1, 1, 5'd3, 16'hBEEF);
    idle(16);
    cycle(0, 0, 0, 5'd3, 16'h0);
    idle(3);
    cycle(0, 1, 0, 5'd0, 16'h0);
    idle(7);
    cycle(1, 0, 0, 5'd0, 16'h0);
    idle(16);
    cycle(0, 0, 1, 5'd7, 16'h0777);
    cycle(0, 0, 0, 5'd7, 16'h0);
    cycle(1, 0, 0, 5'd0, 16'h0);
    idle(18);
    cycle(0, 1, 0, 5'd0, 16'h0);
    idle(5);
    cycle(0, 1, 0, 5'd0, 16'h0);
    idle(17);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 599) == 0, $urandom_range(0, 79) == 0,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)),
            16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
